// File: rtl/fraise_infer_seq_if.sv
// Handshake and array bus of the FRAISE inference sequencer.
// Ports carried:
//   command   : start_i, ready_o, abort_i, obs_i, n_samples_i, seed_i, busy_o
//   array side: seeds_o, load_seed_o, inference_o, addr_col_o, addr_row_o, bit_out_i
//   result    : res_valid_o, res_ready_i, res_data_o
// The slave modport is the sequencer; the master modport is the front-end/array side.
interface fraise_infer_seq_if #(
    parameter int unsigned MatrixSize = 4,
    parameter int unsigned ArraySize  = 64,
    parameter int unsigned SampleCntW = 8,
    parameter int unsigned SeedW      = 8
);
    localparam int unsigned MatrixSizeLog2 = (MatrixSize == 1) ? 1 : $clog2(MatrixSize);
    localparam int unsigned ArraySizeLog2  = (ArraySize == 1) ? 1 : $clog2(ArraySize);
    localparam int unsigned ObsW           = ArraySizeLog2 + 3;
    localparam int unsigned AddrW          = ArraySizeLog2 + MatrixSizeLog2;
    localparam int unsigned ObsBusW        = MatrixSize * ObsW;
    localparam int unsigned ResBusW        = MatrixSize * SampleCntW;

    logic                  start_i;
    logic                  ready_o;
    logic                  abort_i;
    logic [ObsBusW-1:0]    obs_i;
    logic [SampleCntW-1:0] n_samples_i;
    logic [SeedW-1:0]      seed_i;
    logic [SeedW-1:0]      seeds_o;
    logic                  load_seed_o;
    logic                  inference_o;
    logic [AddrW-1:0]      addr_col_o;
    logic [AddrW-1:0]      addr_row_o;
    logic [MatrixSize-1:0] bit_out_i;
    logic                  res_valid_o;
    logic                  res_ready_i;
    logic [ResBusW-1:0]    res_data_o;
    logic                  busy_o;

    modport slave (
        input  start_i, abort_i, obs_i, n_samples_i, seed_i, bit_out_i, res_ready_i,
        output ready_o, seeds_o, load_seed_o, inference_o, addr_col_o, addr_row_o,
               res_valid_o, res_data_o, busy_o
    );

    modport master (
        output start_i, abort_i, obs_i, n_samples_i, seed_i, bit_out_i, res_ready_i,
        input  ready_o, seeds_o, load_seed_o, inference_o, addr_col_o, addr_row_o,
               res_valid_o, res_data_o, busy_o
    );
endinterface

// File: rtl/fraise_infer_seq.sv
// Inference sequencer for the FRAISE Bayesian stochastic array.
// Sequences seed load, one observation write per matrix, then N sampling cycles,
// accumulating each matrix's bit_out into a counter returned via valid/ready.
// Ports:
//   clk_i   : clock
//   reset_n : asynchronous active-low reset
//   bus     : fraise_infer_seq_if.slave (command, array and result signals)
// Configuration macro FRAISE_SEQ_SATURATE_EN: defined -> accumulators saturate
// at all-ones; undefined -> accumulators wrap.
module fraise_infer_seq #(
    parameter int unsigned MatrixSize = 4,
    parameter int unsigned ArraySize  = 64,
    parameter int unsigned SampleCntW = 8,
    parameter int unsigned SeedW      = 8
) (
    input  logic              clk_i,
    input  logic              reset_n,
    fraise_infer_seq_if.slave bus
);
    localparam int unsigned KW            = (MatrixSize == 1) ? 1 : $clog2(MatrixSize);
    localparam int unsigned ArraySizeLog2 = (ArraySize == 1) ? 1 : $clog2(ArraySize);
    localparam int unsigned ObsW          = ArraySizeLog2 + 3;
    localparam int unsigned AddrW         = ArraySizeLog2 + KW;
    localparam int unsigned CntW          = SampleCntW + 1;
    localparam logic [KW-1:0] KLast       = KW'(MatrixSize - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEED  = 3'd1,
        S_WRITE = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [KW-1:0]         k_q, k_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [ObsW-1:0]       obs_q [MatrixSize];
    logic [ObsW-1:0]       obs_d [MatrixSize];
    logic [SampleCntW-1:0] acc_q [MatrixSize];
    logic [SampleCntW-1:0] acc_d [MatrixSize];

    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              load_seed_q, load_seed_d;
    logic              inference_q, inference_d;
    logic              res_valid_q, res_valid_d;
    logic [SeedW-1:0]  seeds_q, seeds_d;
    logic [AddrW-1:0]  addr_col_q, addr_col_d;
    logic [AddrW-1:0]  addr_row_q, addr_row_d;

    // State register
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything, including a start in Idle
    always_comb begin
        state_d = state_q;
        if (bus.abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (bus.start_i)         state_d = S_SEED;
                S_SEED:                           state_d = S_WRITE;
                S_WRITE: if (k_q == KLast)        state_d = S_RUN;
                S_RUN:   if (cnt_q == CntW'(1))   state_d = S_DONE;
                S_DONE:  if (bus.res_ready_i)     state_d = S_IDLE;
                default:                          state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and registered-output next values, derived from the state being entered
    always_comb begin
        k_d        = k_q;
        cnt_d      = cnt_q;
        obs_d      = obs_q;
        acc_d      = acc_q;
        addr_col_d = addr_col_q;
        addr_row_d = addr_row_q;

        case (state_q)
            S_IDLE: begin
                if (state_d == S_SEED) begin
                    for (int unsigned m = 0; m < MatrixSize; m++) begin
                        obs_d[m] = bus.obs_i[m*ObsW +: ObsW];
                        acc_d[m] = '0;
                    end
                    // Zero samples requested means a full 2^SampleCntW run
                    cnt_d = (bus.n_samples_i == '0) ? {1'b1, {SampleCntW{1'b0}}}
                                                    : {1'b0, bus.n_samples_i};
                end
            end
            S_SEED:  k_d = '0;
            S_WRITE: k_d = k_q + KW'(1);
            S_RUN: begin
                if (!bus.abort_i) begin
                    cnt_d = cnt_q - CntW'(1);
                    for (int unsigned m = 0; m < MatrixSize; m++) begin
`ifdef FRAISE_SEQ_SATURATE_EN
                        if (bus.bit_out_i[m] && (acc_q[m] != '1)) begin
                            acc_d[m] = acc_q[m] + SampleCntW'(1);
                        end
`else
                        if (bus.bit_out_i[m]) begin
                            acc_d[m] = acc_q[m] + SampleCntW'(1);
                        end
`endif
                    end
                end
            end
            default: ;
        endcase

        // Column = {matrix, column group, 3'b0}; row = zero-extended row select
        if (state_d == S_WRITE) begin
            addr_col_d = {k_d, ArraySizeLog2'({obs_d[k_d][2:0], 3'b000})};
            addr_row_d = {{KW{1'b0}}, obs_d[k_d][ObsW-1:3]};
        end

        ready_d     = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        load_seed_d = (state_d == S_SEED);
        inference_d = (state_d == S_WRITE);
        res_valid_d = (state_d == S_DONE);
        // Seed is only entered from Idle, so the seed is captured straight from the input
        seeds_d     = (state_d == S_SEED) ? bus.seed_i : '0;
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            k_q         <= '0;
            cnt_q       <= '0;
            for (int unsigned m = 0; m < MatrixSize; m++) begin
                obs_q[m] <= '0;
                acc_q[m] <= '0;
            end
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            load_seed_q <= 1'b0;
            inference_q <= 1'b0;
            res_valid_q <= 1'b0;
            seeds_q     <= '0;
            addr_col_q  <= '0;
            addr_row_q  <= '0;
        end else begin
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            obs_q       <= obs_d;
            acc_q       <= acc_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            load_seed_q <= load_seed_d;
            inference_q <= inference_d;
            res_valid_q <= res_valid_d;
            seeds_q     <= seeds_d;
            addr_col_q  <= addr_col_d;
            addr_row_q  <= addr_row_d;
        end
    end

    // Result bus is the accumulator registers; they only move during Run or at start
    logic [MatrixSize*SampleCntW-1:0] res_data;
    always_comb begin
        res_data = '0;
        for (int unsigned m = 0; m < MatrixSize; m++) begin
            res_data[m*SampleCntW +: SampleCntW] = acc_q[m];
        end
    end

    assign bus.ready_o     = ready_q;
    assign bus.busy_o      = busy_q;
    assign bus.load_seed_o = load_seed_q;
    assign bus.inference_o = inference_q;
    assign bus.res_valid_o = res_valid_q;
    assign bus.seeds_o     = seeds_q;
    assign bus.addr_col_o  = addr_col_q;
    assign bus.addr_row_o  = addr_row_q;
    assign bus.res_data_o  = res_data;
endmodule

// File: tb/tb_fraise_infer_seq.sv
// Self-checking bench for fraise_infer_seq: directed scenarios push expected
// results into a queue; a monitor pops and compares on each result handshake.
module tb_fraise_infer_seq;
    localparam int unsigned MS   = 4;
    localparam int unsigned AS   = 64;
    localparam int unsigned SCW  = 8;
    localparam int unsigned SDW  = 8;
    localparam int unsigned OBSW = 36;
    localparam int unsigned RESW = 32;

    logic clk;
    logic rst_n;

    int checks;
    int errors;
    int popped;
    logic [RESW-1:0] exp_q[$];

    fraise_infer_seq_if #(.MatrixSize(MS), .ArraySize(AS), .SampleCntW(SCW), .SeedW(SDW)) dut_if ();

    fraise_infer_seq #(.MatrixSize(MS), .ArraySize(AS), .SampleCntW(SCW), .SeedW(SDW)) dut (
        .clk_i   (clk),
        .reset_n (rst_n),
        .bus     (dut_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [OBSW-1:0] obs, input logic [SCW-1:0] n,
                            input logic [SDW-1:0] seed);
        dut_if.obs_i       = obs;
        dut_if.n_samples_i = n;
        dut_if.seed_i      = seed;
        dut_if.start_i     = 1'b1;
        step();
        dut_if.start_i     = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int edges);
        edges = 0;
        while (dut_if.res_valid_o !== 1'b1 && edges < limit) begin
            step();
            edges++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},     64'(dut_if.ready_o), 64'd1);
        chk({tag, "_busy"},      64'(dut_if.busy_o), 64'd0);
        chk({tag, "_load_seed"}, 64'(dut_if.load_seed_o), 64'd0);
        chk({tag, "_inference"}, 64'(dut_if.inference_o), 64'd0);
        chk({tag, "_addr_col"},  64'(dut_if.addr_col_o), 64'd0);
        chk({tag, "_addr_row"},  64'(dut_if.addr_row_o), 64'd0);
        chk({tag, "_seeds"},     64'(dut_if.seeds_o), 64'd0);
        chk({tag, "_res_valid"}, 64'(dut_if.res_valid_o), 64'd0);
        chk({tag, "_res_data"},  64'(dut_if.res_data_o), 64'd0);
    endtask

    // Scoreboard monitor: compares on every cycle where the result handshake will fire
    initial begin
        logic [RESW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && dut_if.res_valid_o === 1'b1 && dut_if.res_ready_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0h expected no result", dut_if.res_data_o);
                end else begin
                    e = exp_q.pop_front();
                    popped++;
                    chk("result", 64'(dut_if.res_data_o), 64'(e));
                end
            end
        end
    end

    initial begin
        int edges;
        int seen_valid;
        checks = 0;
        errors = 0;
        popped = 0;
        dut_if.start_i     = 1'b0;
        dut_if.abort_i     = 1'b0;
        dut_if.obs_i       = '0;
        dut_if.n_samples_i = '0;
        dut_if.seed_i      = '0;
        dut_if.bit_out_i   = '0;
        dut_if.res_ready_i = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk_reset_vals("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Addressing: seed strobe then one observation write per matrix
        dut_if.bit_out_i = 4'b1000;
        exp_q.push_back(32'h03000000);
        do_start({9'h13A, 9'h008, 9'h1FF, 9'h0D5}, 8'd3, 8'hA5);
        chk("seed_load",  64'(dut_if.load_seed_o), 64'd1);
        chk("seed_value", 64'(dut_if.seeds_o), 64'hA5);
        chk("seed_busy",  64'(dut_if.busy_o), 64'd1);
        chk("seed_ready", 64'(dut_if.ready_o), 64'd0);
        chk("seed_inf",   64'(dut_if.inference_o), 64'd0);
        step();
        chk("k0_load", 64'(dut_if.load_seed_o), 64'd0);
        chk("k0_inf",  64'(dut_if.inference_o), 64'd1);
        chk("k0_col",  64'(dut_if.addr_col_o), 64'h28);
        chk("k0_row",  64'(dut_if.addr_row_o), 64'h1A);
        step();
        chk("k1_inf",  64'(dut_if.inference_o), 64'd1);
        chk("k1_col",  64'(dut_if.addr_col_o), 64'h78);
        chk("k1_row",  64'(dut_if.addr_row_o), 64'h3F);
        step();
        chk("k2_col",  64'(dut_if.addr_col_o), 64'h80);
        chk("k2_row",  64'(dut_if.addr_row_o), 64'h01);
        step();
        chk("k3_inf",  64'(dut_if.inference_o), 64'd1);
        chk("k3_col",  64'(dut_if.addr_col_o), 64'hD0);
        chk("k3_row",  64'(dut_if.addr_row_o), 64'h27);
        step();
        chk("run_inf",      64'(dut_if.inference_o), 64'd0);
        chk("run_col_hold", 64'(dut_if.addr_col_o), 64'hD0);
        wait_valid(50, edges);
        chk("addr_run_len", 64'(edges), 64'd3);
        step();
        chk("addr_ready_back", 64'(dut_if.ready_o), 64'd1);

        // Accumulation with constant bit pattern
        dut_if.bit_out_i = 4'b0101;
        exp_q.push_back(32'h000A000A);
        do_start({9'h001, 9'h002, 9'h003, 9'h004}, 8'd10, 8'h11);
        wait_valid(200, edges);
        chk("acc_latency", 64'(edges), 64'd15);
        step();
        chk("acc_ready_back", 64'(dut_if.ready_o), 64'd1);

        // Zero samples means 256 Run cycles; counter wraps or saturates
        dut_if.bit_out_i = 4'b0001;
`ifdef FRAISE_SEQ_SATURATE_EN
        exp_q.push_back(32'h000000FF);
`else
        exp_q.push_back(32'h00000000);
`endif
        do_start('0, 8'd0, 8'h22);
        wait_valid(400, edges);
        chk("wrap_latency", 64'(edges), 64'd261);
        step();

        // Backpressure: result held, starts ignored
        dut_if.res_ready_i = 1'b0;
        dut_if.bit_out_i   = 4'b0011;
        exp_q.push_back(32'h00000202);
        do_start('0, 8'd2, 8'h33);
        wait_valid(50, edges);
        chk("bp_latency", 64'(edges), 64'd7);
        for (int i = 0; i < 5; i++) begin
            dut_if.start_i     = (i % 2 == 0);
            dut_if.n_samples_i = 8'd99;
            chk("bp_data",  64'(dut_if.res_data_o), 64'h00000202);
            chk("bp_ready", 64'(dut_if.ready_o), 64'd0);
            chk("bp_valid", 64'(dut_if.res_valid_o), 64'd1);
            step();
        end
        dut_if.start_i     = 1'b0;
        dut_if.res_ready_i = 1'b1;
        chk("bp_data_last", 64'(dut_if.res_data_o), 64'h00000202);
        step();
        chk("bp_ready_back", 64'(dut_if.ready_o), 64'd1);
        chk("bp_valid_drop", 64'(dut_if.res_valid_o), 64'd0);
        step();
        chk("bp_no_queued_start", 64'(dut_if.busy_o), 64'd0);

        // Abort in the third Run cycle
        dut_if.bit_out_i = 4'b1111;
        do_start('0, 8'd10, 8'h44);
        for (int i = 0; i < 7; i++) step();
        chk("abort_pre_busy", 64'(dut_if.busy_o), 64'd1);
        dut_if.abort_i = 1'b1;
        step();
        dut_if.abort_i = 1'b0;
        chk("abort_ready", 64'(dut_if.ready_o), 64'd1);
        chk("abort_busy",  64'(dut_if.busy_o), 64'd0);
        chk("abort_inf",   64'(dut_if.inference_o), 64'd0);
        seen_valid = 0;
        for (int i = 0; i < 20; i++) begin
            if (dut_if.res_valid_o === 1'b1) seen_valid = 1;
            step();
        end
        chk("abort_no_valid", 64'(seen_valid), 64'd0);

        // Abort beats start in Idle
        dut_if.start_i = 1'b1;
        dut_if.abort_i = 1'b1;
        step();
        dut_if.start_i = 1'b0;
        dut_if.abort_i = 1'b0;
        chk("abort_start_ready", 64'(dut_if.ready_o), 64'd1);
        chk("abort_start_seed",  64'(dut_if.load_seed_o), 64'd0);

        // Restart after abort: accumulators cleared
        exp_q.push_back(32'h04040404);
        do_start('0, 8'd4, 8'h55);
        wait_valid(50, edges);
        chk("post_abort_latency", 64'(edges), 64'd9);
        step();

        // Reset mid-WriteObs
        do_start({9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF}, 8'd5, 8'h66);
        step();
        chk("mid_inf", 64'(dut_if.inference_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        step();
        rst_n = 1'b1;
        step();
        dut_if.bit_out_i = 4'b0110;
        exp_q.push_back(32'h00050500);
        do_start('0, 8'd5, 8'h77);
        wait_valid(50, edges);
        chk("post_reset_latency", 64'(edges), 64'd10);
        step();
        step();

        chk("sb_empty",  64'(exp_q.size()), 64'd0);
        chk("sb_popped", 64'(popped), 64'd6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fraise_infer_seq.md
# fraise_infer_seq

Inference sequencer for the FRAISE Bayesian stochastic array. It sits between the accelerator's register front-end and the `Bayesian_stoch_log` macro. On a start command it sequences one inference: seed load, then one observation write per matrix, then N stochastic sampling cycles. During sampling it accumulates each matrix's `bit_out` into a per-matrix counter and returns the counts through a valid/ready result handshake.

## Interface
- `MatrixSize`, 4: number of matrices (rows of `bit_out`); log2 width is 1 when the value is 1.
- `ArraySize`, 64: words per array; `ArraySizeLog2` = `$clog2` (1 when 1).
- `SampleCntW`, 8: width of the sample-count input and of each result accumulator.
- `SeedW`, 8: seed width.
- Derived: `ObsW = ArraySizeLog2+3`; `AddrW = ArraySizeLog2+MatrixSizeLog2`.

Ports:
- `clk_i` in 1: clock, single clock domain.
- `reset_n` in 1: reset, asynchronous, active-low.
- `start_i` in 1: request one inference; accepted only on a cycle where `ready_o`=1.
- `ready_o` out 1: sequencer is idle and will accept `start_i`.
- `abort_i` in 1: cancels any operation in progress.
- `obs_i` in MatrixSize*ObsW: observation per matrix k. Bits [2:0] select the column group; bits [ObsW-1:3] select the row.
- `n_samples_i` in SampleCntW: number of Run cycles; 0 means 2^SampleCntW.
- `seed_i` in SeedW: seed value.
- `seeds_o` out SeedW: seed presented to the array.
- `load_seed_o` out 1: load-seed strobe.
- `inference_o` out 1: observation-write strobe.
- `addr_col_o` out AddrW: array column address.
- `addr_row_o` out AddrW: array row address.
- `bit_out_i` in MatrixSize: stochastic output bits from the array.
- `res_valid_o` out 1: result available.
- `res_ready_i` in 1: consumer accepts the result.
- `res_data_o` out MatrixSize*SampleCntW: per-matrix counts; matrix k occupies slice k.
- `busy_o` out 1: high in every state except Idle.

## Operation
- States and behaviour:
  - **Idle:** `ready_o`=1. When `start_i`=1, latch `obs_i`, `n_samples_i` and `seed_i`, clear all accumulators, and go to Seed.
  - **Seed:** lasts 1 cycle. `load_seed_o`=1 and `seeds_o` = latched seed. Go to WriteObs with the matrix index k=0.
  - **WriteObs:** lasts MatrixSize cycles. `inference_o`=1.
    - `addr_col_o` = {k, obs[k][2:0], 3'b0}.
    - `addr_row_o` = {MatrixSizeLog2 zeros, obs[k][ObsW-1:3]}.
    - k increments each cycle. After k=MatrixSize-1, go to Run.
  - **Run:** lasts exactly N cycles (N = latched value; 0 means 2^SampleCntW).
    - Each cycle: acc[k] += `bit_out_i[k]` for every k.
    - `inference_o`=0; addresses hold their last values.
    - The sample counter is SampleCntW+1 bits wide so that 2^SampleCntW samples can be counted.
  - **Done:** `res_valid_o`=1 and `res_data_o` = accumulators, held stable. When `res_valid_o`&`res_ready_i`, go to Idle.
- Inputs are sampled only at start acceptance; changes to `obs_i`, `n_samples_i` or `seed_i` during an operation are ignored.
- `start_i` while `ready_o`=0 is ignored and is not queued.
- `abort_i`=1 in any state: next state is Idle, all strobes deasserted, `res_valid_o` never raised. Accumulators keep their values but are cleared on the next start.
- If `abort_i` and `start_i` are both high in Idle, abort wins and no operation starts.
- A `bit_out_i` value outside Run is ignored.

## Timing
- Reset (asynchronous assert, synchronous deassert use): state = Idle; `ready_o`=1. All other outputs are 0: `busy_o`, `load_seed_o`, `inference_o`, addresses, `seeds_o`, `res_valid_o`, `res_data_o`, accumulators.
- Reset asserted mid-operation aborts immediately, with the same values as at reset.
- All outputs are registered and change only on `clk_i` rising edges.
- Counting from the accepting edge E0:
  - `load_seed_o` is high during cycle E0..E0+1.
  - `inference_o` is high for edges E0+1 through E0+1+MatrixSize.
  - `res_valid_o` is first high after edge E0+1+MatrixSize+N.
- `ready_o` returns to 1 on the edge that completes the result handshake. A new start can be accepted on the following edge.
- `res_data_o` must not change while `res_valid_o`=1.

## Configuration
- Macro: `FRAISE_SEQ_SATURATE_EN`.
  - Defined: accumulators saturate at 2^SampleCntW-1.
  - Undefined: accumulators wrap modulo 2^SampleCntW.

## Test plan
- **Addressing:** MatrixSize=4, ArraySize=64, obs[0]=9'h0D5, start → `load_seed_o` for 1 cycle, then 4 `inference_o` cycles. For k=0: `addr_col_o`=8'h28, `addr_row_o`=8'h1A; for k=1..3 the upper two bits of `addr_col_o` equal k.
- **Accumulation:** n_samples=10, bit_out=4'b0101 constant → res_valid 15 edges after E0; res_data slices = {0,10,0,10}.
- **Sample-count wrap:** n_samples=0, bit_out=4'b0001 → 256 Run cycles. res_data[0]=255 with `FRAISE_SEQ_SATURATE_EN`, 0 without it.
- **Backpressure:** res_ready_i held low 5 cycles → res_data stable and ready_o=0 throughout; start_i pulses ignored. res_ready_i=1 → Idle, ready_o=1 next edge.
- **Abort:** abort_i asserted in the 3rd Run cycle → Idle next edge, res_valid_o never set. A following start with n_samples=4 and bit_out=4'b1111 returns 4 in every slice (accumulators cleared).
- **Reset mid-run:** reset_n dropped mid-WriteObs → all outputs at reset values without a clock edge. After release, a start produces a normal result.
